multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 29 ++
 rtl/multicycle_alu_if.sv | 27 ++
 rtl/muldiv_iter.sv | 105 ++++++++++
 rtl/multicycle_alu.sv | 122 ++++++++++++
 tb/tb_multicycle_alu.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and data width for multicycle_alu
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULT = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - request/result bundle between requester and multicycle_alu
interface multicycle_alu_if;
  import alu_pkg::*;

  logic              start;
  logic [3:0]        ALU_Control;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] ALU_Result;
  logic              Zero;
  logic [DATA_W-1:0] Hi;
  logic [DATA_W-1:0] Lo;
  logic              busy;
  logic              done;

  modport master (
    output start, ALU_Control, A, B, shamt,
    input  ALU_Result, Zero, Hi, Lo, busy, done
  );

  modport slave (
    input  start, ALU_Control, A, B, shamt,
    output ALU_Result, Zero, Hi, Lo, busy, done
  );

endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - 32-step shift-add multiplier / restoring divider on magnitudes
// Sign correction is applied combinationally to the accumulator; the caller registers it.
module muldiv_iter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              is_div,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              last,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                div_q, div_d;
  logic                neg_q, neg_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dbz_q, dbz_d;

  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W+1:0]   div_diff;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo, rem;

  always_comb begin
    a_mag     = a[DATA_W-1] ? -a : a;
    b_mag     = b[DATA_W-1] ? -b : b;
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, dvs_q};
    // Remainder is shifted left first, so it can momentarily need 33 bits.
    div_diff  = {1'b0, acc_q[2*DATA_W-1:DATA_W-1]} - {2'b00, dvs_q};

    acc_d     = acc_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;

    if (load) begin
      acc_d     = {{DATA_W{1'b0}}, a_mag};
      dvs_d     = b_mag;
      cnt_d     = 5'd0;
      div_d     = is_div;
      neg_d     = a[DATA_W-1] ^ b[DATA_W-1];
      neg_rem_d = a[DATA_W-1];
      dbz_d     = (b == '0);
    end else if (step) begin
      cnt_d = cnt_q + 5'd1;
      if (div_q) begin
        if (!div_diff[DATA_W+1])
          acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        else
          acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
      end else begin
        if (acc_q[0])
          acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        else
          acc_d = {1'b0, acc_q[2*DATA_W-1:1]};
      end
    end
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[DATA_W-1:0];
    rem  = acc_q[2*DATA_W-1:DATA_W];
    if (div_q) begin
      lo = dbz_q ? '1 : (neg_q ? -quo : quo);
      hi = neg_rem_q ? -rem : rem;
    end else begin
      lo = prod[DATA_W-1:0];
      hi = prod[2*DATA_W-1:DATA_W];
    end
    last = (cnt_q == 5'd31);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= 5'd0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - single-cycle ALU plus FSM sequencing iterative mult/div
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_alu_if.slave  bus
);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic [DATA_W-1:0] alu_out;
  logic              md_load, md_step, md_last;
  logic [DATA_W-1:0] md_hi, md_lo;

  muldiv_iter u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .load   (md_load),
    .is_div (bus.ALU_Control == OP_DIV),
    .step   (md_step),
    .a      (bus.A),
    .b      (bus.B),
    .last   (md_last),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  always_comb begin
    case (bus.ALU_Control)
      OP_AND:  alu_out = bus.A & bus.B;
      OP_OR:   alu_out = bus.A | bus.B;
      OP_ADD:  alu_out = bus.A + bus.B;
      OP_SUB:  alu_out = bus.A - bus.B;
      OP_NOR:  alu_out = ~(bus.A | bus.B);
      OP_XOR:  alu_out = bus.A ^ bus.B;
      OP_SLT:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLL:  alu_out = bus.B << bus.shamt;
      OP_SRL:  alu_out = bus.B >> bus.shamt;
      OP_SRA:  alu_out = DATA_W'($signed(bus.B) >>> bus.shamt);
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    zero_d   = zero_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    md_load  = 1'b0;
    md_step  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_muldiv(bus.ALU_Control)) begin
            md_load = 1'b1;
            busy_d  = 1'b1;
            state_d = ITER;
          end else begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            done_d   = 1'b1;
          end
        end
      end
      ITER: begin
        md_step = 1'b1;
        if (md_last) state_d = FIX;
      end
      FIX: begin
        hi_d     = md_hi;
        lo_d     = md_lo;
        result_d = md_lo;
        zero_d   = (md_lo == '0);
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b1;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.ALU_Result = result_q;
  assign bus.Zero       = zero_q;
  assign bus.Hi         = hi_q;
  assign bus.Lo         = lo_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed vector bench for multicycle_alu
module tb_multicycle_alu;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
  } sc_vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failures = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  sc_vec_t sc[15];
  md_vec_t md[9];

  multicycle_alu_if bus();

  multicycle_alu u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    bus.start = st;
    bus.ALU_Control = op;
    bus.A = a;
    bus.B = b;
    bus.shamt = sh;
  endtask

  task automatic run_single(input sc_vec_t v, input string tag);
    drive(1'b1, v.op, v.a, v.b, v.sh);
    tick();
    bus.start = 1'b0;
    check({tag, " result"}, v.res ? 64'(bus.ALU_Result) : 64'(bus.ALU_Result), 64'(v.res));
    check({tag, " zero"}, 64'(bus.Zero), 64'(v.zero));
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    check({tag, " hi/lo held"}, {bus.Hi, bus.Lo}, {exp_hi, exp_lo});
    tick();
    check({tag, " done drop"}, 64'(bus.done), 64'd0);
  endtask

  // poke_cycle > 0 injects an extra start (add 1+1) in that cycle of the operation.
  task automatic run_muldiv(input md_vec_t v, input int poke_cycle, input string tag);
    int busy_cnt;
    int done_cyc;
    busy_cnt = 0;
    done_cyc = 0;
    drive(1'b1, v.op, v.a, v.b, 5'd0);
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cyc = c;
        check({tag, " busy at done"}, 64'(bus.busy), 64'd0);
      end else begin
        if (c == poke_cycle) drive(1'b1, OP_ADD, 32'd1, 32'd1, 5'd0);
        tick();
        bus.start = 1'b0;
      end
    end
    exp_hi = v.hi;
    exp_lo = v.lo;
    check({tag, " done cycle"}, 64'(done_cyc), 64'd34);
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " hi"}, 64'(bus.Hi), 64'(v.hi));
    check({tag, " lo"}, 64'(bus.Lo), 64'(v.lo));
    check({tag, " result"}, 64'(bus.ALU_Result), 64'(v.lo));
    check({tag, " zero"}, 64'(bus.Zero), 64'(v.lo == 32'd0));
    tick();
    check({tag, " done drop"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int dones;
    sc[0]  = '{OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0};
    sc[1]  = '{OP_OR,  32'hF0F00000, 32'h00001234, 5'd0,  32'hF0F01234, 1'b0};
    sc[2]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0};
    sc[3]  = '{OP_SUB, 32'd5,        32'd5,        5'd0,  32'h00000000, 1'b1};
    sc[4]  = '{OP_SUB, 32'd0,        32'd1,        5'd0,  32'hFFFFFFFF, 1'b0};
    sc[5]  = '{OP_NOR, 32'h0000FFFF, 32'h00FF0000, 5'd0,  32'hFF000000, 1'b0};
    sc[6]  = '{OP_XOR, 32'hAAAA5555, 32'hFFFF0000, 5'd0,  32'h55555555, 1'b0};
    sc[7]  = '{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0};
    sc[8]  = '{OP_SLT, 32'd5,        32'hFFFFFFFE, 5'd0,  32'h00000000, 1'b1};
    sc[9]  = '{OP_SLL, 32'h12345678, 32'h00000001, 5'd31, 32'h80000000, 1'b0};
    sc[10] = '{OP_SRL, 32'hFFFFFFFF, 32'h80000000, 5'd4,  32'h08000000, 1'b0};
    sc[11] = '{OP_SRA, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0};
    sc[12] = '{OP_SRA, 32'h00000000, 32'h40000000, 5'd4,  32'h04000000, 1'b0};
    sc[13] = '{4'b0011, 32'd1,       32'd2,        5'd3,  32'h00000000, 1'b1};
    sc[14] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000000, 1'b1};

    md[0] = '{OP_MULT, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    md[1] = '{OP_MULT, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    md[2] = '{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    md[3] = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    md[4] = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    md[5] = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    md[6] = '{OP_DIV,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF};
    md[7] = '{OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    md[8] = '{OP_DIV,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};

    drive(1'b0, OP_AND, 32'd0, 32'd0, 5'd0);
    repeat (3) tick();
    reset = 1'b0;
    check("reset result", 64'(bus.ALU_Result), 64'd0);
    check("reset zero", 64'(bus.Zero), 64'd1);
    check("reset hi", 64'(bus.Hi), 64'd0);
    check("reset lo", 64'(bus.Lo), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);

    for (int i = 0; i < 9; i++) run_muldiv(md[i], 0, $sformatf("md%0d", i));
    for (int i = 0; i < 15; i++) run_single(sc[i], $sformatf("sc%0d", i));

    // Extra start while busy must be dropped without disturbing the operands.
    run_muldiv(md[0], 5, "ignored start");

    // Start in the done cycle is accepted and completes one cycle later.
    drive(1'b1, OP_MULT, 32'hFFFFFFFD, 32'd7, 5'd0);
    tick();
    bus.start = 1'b0;
    repeat (33) tick();
    check("chain mult done", 64'(bus.done), 64'd1);
    check("chain mult lo", 64'(bus.Lo), 64'hFFFFFFEB);
    drive(1'b1, OP_ADD, 32'd2, 32'd3, 5'd0);
    tick();
    bus.start = 1'b0;
    check("chain add done", 64'(bus.done), 64'd1);
    check("chain add result", 64'(bus.ALU_Result), 64'd5);
    check("chain add busy", 64'(bus.busy), 64'd0);
    check("chain add hi held", 64'(bus.Hi), 64'hFFFFFFFF);

    // Reset mid-operation (with a simultaneous start) aborts with no done pulse.
    drive(1'b1, OP_MULT, 32'hFFFFFFFD, 32'd7, 5'd0);
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    check("pre-reset busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    drive(1'b1, OP_ADD, 32'd5, 32'd6, 5'd0);
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort result", 64'(bus.ALU_Result), 64'd0);
    check("abort zero", 64'(bus.Zero), 64'd1);
    check("abort hi", 64'(bus.Hi), 64'd0);
    check("abort lo", 64'(bus.Lo), 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    check("abort no done/busy", 64'(dones), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
